// File: rtl/bus_read_queue_if.sv
// Handshake/bus bundle between the inter-PE bus, the PE datapath and bus_read_queue.
interface bus_read_queue_if #(
    parameter int DATA_LEN     = 16,
    parameter int BUS_ADDR_LEN = 3,
    parameter int NUM_ELEM     = 8
);
    logic                    stall;
    logic [DATA_LEN-1:0]     data_from_bus;
    logic [BUS_ADDR_LEN-1:0] addr_from_bus;
    logic                    valid_from_bus;
    logic [BUS_ADDR_LEN-1:0] src_addr_in;
    logic                    src_rq_in;
    logic [DATA_LEN-1:0]     src_data_r;
    logic                    src_valid_r;
    logic                    src_busy;
    logic [NUM_ELEM-1:0]     rd_buffer_full;
    logic                    ovf_flag;

    modport slave (
        input  stall, data_from_bus, addr_from_bus, valid_from_bus, src_addr_in, src_rq_in,
        output src_data_r, src_valid_r, src_busy, rd_buffer_full, ovf_flag
    );

    modport master (
        output stall, data_from_bus, addr_from_bus, valid_from_bus, src_addr_in, src_rq_in,
        input  src_data_r, src_valid_r, src_busy, rd_buffer_full, ovf_flag
    );
endinterface

// File: rtl/bus_read_queue.sv
// Per-PE bus receive queue: one FIFO per source channel, one source-addressed read per request.
// Define BUS_READ_OVF_FLAG_EN to build the sticky overflow detector; otherwise ovf_flag is 0.

module bus_read_queue_chan #(
    parameter int DATA_LEN   = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_MARGIN  = 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                push,
    input  logic                pop,
    input  logic [DATA_LEN-1:0] din,
    output logic [DATA_LEN-1:0] head,
    output logic                nempty,
    output logic                af,
    output logic                ovf
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_LEN-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]       wp_q, rp_q;
    logic [CW-1:0]       cnt_q;
    logic                af_q;
    logic                full, wr;

    assign full = (cnt_q == CW'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
    assign wr   = push && (!full || pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            af_q  <= 1'b0;
        end else begin
            if (wr)  wp_q <= wp_q + AW'(1);
            if (pop) rp_q <= rp_q + AW'(1);
            cnt_q <= cnt_q + CW'(wr) - CW'(pop);
            af_q  <= (cnt_q >= CW'(FIFO_DEPTH - AF_MARGIN));
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wp_q] <= din;
    end

    assign head   = mem[rp_q];
    assign nempty = (cnt_q != '0);
    assign af     = af_q;

`ifdef BUS_READ_OVF_FLAG_EN
    logic ovf_q;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                     ovf_q <= 1'b0;
        else if (push && full && !pop) ovf_q <= 1'b1;
    end
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif
endmodule

module bus_read_queue #(
    parameter int          DATA_LEN     = 16,
    parameter int          BUS_ADDR_LEN = 3,
    parameter int          NUM_ELEM     = 8,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          AF_MARGIN    = 1,
    parameter logic [31:0] EXCLUDE_MASK = 32'h0
) (
    input  logic           clk,
    input  logic           rstn,
    bus_read_queue_if.slave bus
);
    localparam int NSLOT = 1 << BUS_ADDR_LEN;

    typedef enum logic {S_IDLE, S_WAIT} rq_state_t;

    function automatic logic excluded(input int i);
        return (i < 32) && EXCLUDE_MASK[i[4:0]];
    endfunction

    logic [DATA_LEN-1:0]            data_q;
    logic [BUS_ADDR_LEN-1:0]        addr_q;
    logic                           valid_q;
    logic [NSLOT-1:0][DATA_LEN-1:0] head_ext;
    logic [NSLOT-1:0]               nempty_ext;
    logic [NUM_ELEM-1:0]            af_v, ovf_v;
    rq_state_t                      state_q, state_d;
    logic [BUS_ADDR_LEN-1:0]        raddr_q, raddr_d;
    logic                           pop_fire;
    logic [DATA_LEN-1:0]            src_data_q;
    logic                           src_valid_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q  <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= bus.data_from_bus;
            addr_q  <= bus.addr_from_bus;
            valid_q <= bus.valid_from_bus;
        end
    end

    // Every tag value gets a slot; out-of-range and excluded slots read as permanently empty.
    for (genvar i = 0; i < NSLOT; i++) begin : g_ch
        if (i < NUM_ELEM && !excluded(i)) begin : g_fifo
            logic push, pop;
            assign push = valid_q  && (addr_q  == BUS_ADDR_LEN'(i));
            assign pop  = pop_fire && (raddr_q == BUS_ADDR_LEN'(i));
            bus_read_queue_chan #(
                .DATA_LEN  (DATA_LEN),
                .FIFO_DEPTH(FIFO_DEPTH),
                .AF_MARGIN (AF_MARGIN)
            ) u_chan (
                .clk   (clk),
                .rstn  (rstn),
                .push  (push),
                .pop   (pop),
                .din   (data_q),
                .head  (head_ext[i]),
                .nempty(nempty_ext[i]),
                .af    (af_v[i]),
                .ovf   (ovf_v[i])
            );
        end else begin : g_none
            assign head_ext[i]   = '0;
            assign nempty_ext[i] = 1'b0;
            if (i < NUM_ELEM) begin : g_flags
                assign af_v[i]  = 1'b0;
                assign ovf_v[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            raddr_q <= '0;
        end else begin
            state_q <= state_d;
            raddr_q <= raddr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        raddr_d  = raddr_q;
        pop_fire = 1'b0;
        if (!bus.stall) begin
            case (state_q)
                S_IDLE: if (bus.src_rq_in) begin
                    state_d = S_WAIT;
                    raddr_d = bus.src_addr_in;
                end
                S_WAIT: if (nempty_ext[raddr_q]) begin
                    pop_fire = 1'b1;
                    state_d  = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Stall freezes the read port so the datapath sees the same word until it moves on.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            src_valid_q <= 1'b0;
            src_data_q  <= '0;
        end else if (!bus.stall) begin
            src_valid_q <= pop_fire;
            if (pop_fire) src_data_q <= head_ext[raddr_q];
        end
    end

    assign bus.src_data_r     = src_data_q;
    assign bus.src_valid_r    = src_valid_q;
    assign bus.src_busy       = (state_q == S_WAIT) && !nempty_ext[raddr_q];
    assign bus.rd_buffer_full = af_v;
    assign bus.ovf_flag       = |ovf_v;
endmodule

// File: tb/tb_bus_read_queue.sv
// Directed bench for bus_read_queue (DEPTH 8, AF_MARGIN 1, EXCLUDE_MASK 0x81).
module tb_bus_read_queue;
    logic clk  = 1'b0;
    logic rstn = 1'b1;
    int   nvec = 0;
    int   nerr = 0;

`ifdef BUS_READ_OVF_FLAG_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    bus_read_queue_if #(.DATA_LEN(16), .BUS_ADDR_LEN(3), .NUM_ELEM(8)) bus ();

    bus_read_queue #(
        .DATA_LEN(16), .BUS_ADDR_LEN(3), .NUM_ELEM(8),
        .FIFO_DEPTH(8), .AF_MARGIN(1), .EXCLUDE_MASK(32'h81)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] tag, input logic [15:0] d);
        bus.valid_from_bus = 1'b1;
        bus.addr_from_bus  = tag;
        bus.data_from_bus  = d;
        tick();
        bus.valid_from_bus = 1'b0;
    endtask

    // Hit read: expects the word two edges after the request.
    task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string tag);
        int n;
        bus.src_rq_in   = 1'b1;
        bus.src_addr_in = a;
        tick();
        bus.src_rq_in = 1'b0;
        tick();
        n = 0;
        while (!bus.src_valid_r && n < 16) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, 0);
        chk({tag, "_vld"}, bus.src_valid_r, 1'b1);
        chk({tag, "_dat"}, bus.src_data_r, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        bus.stall = 0; bus.data_from_bus = 0; bus.addr_from_bus = 0; bus.valid_from_bus = 0;
        bus.src_addr_in = 0; bus.src_rq_in = 0;
        #2 rstn = 1'b0;
        tick(); tick();
        chk("rst_vld",  bus.src_valid_r, 0);
        chk("rst_dat",  bus.src_data_r, 0);
        chk("rst_busy", bus.src_busy, 0);
        chk("rst_af",   bus.rd_buffer_full, 0);
        chk("rst_ovf",  bus.ovf_flag, 0);
        rstn = 1'b1;
        tick();

        // 1: basic hit
        push(3'd2, 16'h1234);
        tick();
        rd(3'd2, 16'h1234, "t1");
        tick();
        chk("t1_pulse", bus.src_valid_r, 0);

        // 2: request on empty channel waits, then served
        bus.src_addr_in = 3'd3; bus.src_rq_in = 1'b1;
        tick();
        bus.src_rq_in = 1'b0;
        chk("t2_busy0", bus.src_busy, 1);
        tick();
        chk("t2_busy1", bus.src_busy, 1);
        chk("t2_novld", bus.src_valid_r, 0);
        push(3'd3, 16'hBEEF);
        chk("t2_busy2", bus.src_busy, 1);
        tick();
        chk("t2_busyclr", bus.src_busy, 0);
        tick();
        chk("t2_vld", bus.src_valid_r, 1);
        chk("t2_dat", bus.src_data_r, 16'hBEEF);
        tick();
        chk("t2_pulse", bus.src_valid_r, 0);

        // 4: stall holds output and blocks capture/pop
        push(3'd2, 16'h00A1);
        push(3'd2, 16'h00A2);
        tick();
        rd(3'd2, 16'h00A1, "t4a");
        bus.stall = 1'b1; bus.src_rq_in = 1'b1; bus.src_addr_in = 3'd2;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t4_hold_vld", bus.src_valid_r, 1);
            chk("t4_hold_dat", bus.src_data_r, 16'h00A1);
        end
        bus.stall = 1'b0; bus.src_rq_in = 1'b0;
        tick();
        chk("t4_drop", bus.src_valid_r, 0);
        rd(3'd2, 16'h00A2, "t4b");
        push(3'd2, 16'h00A3);
        tick();
        bus.src_rq_in = 1'b1; bus.src_addr_in = 3'd2;
        tick();
        bus.src_rq_in = 1'b0; bus.stall = 1'b1;
        tick(); tick();
        chk("t4_wait_stall", bus.src_valid_r, 0);
        bus.stall = 1'b0;
        tick();
        chk("t4c_vld", bus.src_valid_r, 1);
        chk("t4c_dat", bus.src_data_r, 16'h00A3);

        // 5: excluded channels swallow words silently
        for (int k = 0; k < 9; k++) push(3'd7, 16'(k));
        push(3'd0, 16'h1111);
        tick(); tick();
        chk("t5_af",  bus.rd_buffer_full, 0);
        chk("t5_ovf", bus.ovf_flag, 0);

        // 3: fill, almost-full, overflow, ordered drain
        for (int k = 1; k <= 9; k++) begin
            bus.valid_from_bus = 1'b1; bus.addr_from_bus = 3'd1; bus.data_from_bus = 16'(k);
            tick();
            if (k == 8) chk("t3_af_lag", bus.rd_buffer_full[1], 0);
            if (k == 9) chk("t3_af_set", bus.rd_buffer_full[1], 1);
        end
        bus.valid_from_bus = 1'b0;
        tick();
        chk("t3_ovf", bus.ovf_flag, OVF_EXP);
        chk("t3_af",  bus.rd_buffer_full, 8'h02);
        for (int k = 1; k <= 8; k++) rd(3'd1, 16'(k), "t3_rd");
        tick(); tick();
        chk("t3_af_clr", bus.rd_buffer_full, 0);
        bus.src_rq_in = 1'b1; bus.src_addr_in = 3'd1;
        tick();
        bus.src_rq_in = 1'b0;
        chk("t3_9th_dropped", bus.src_busy, 1);
        push(3'd1, 16'h5A5A);
        tick(); tick();
        chk("t3_next_vld", bus.src_valid_r, 1);
        chk("t3_next_dat", bus.src_data_r, 16'h5A5A);

        // async reset mid-operation
        for (int k = 0; k < 7; k++) push(3'd2, 16'h2000 + 16'(k));
        tick(); tick();
        chk("rs_af_pre", bus.rd_buffer_full, 8'h04);
        #2 rstn = 1'b0;
        #1;
        chk("rs_af",  bus.rd_buffer_full, 0);
        chk("rs_ovf", bus.ovf_flag, 0);
        chk("rs_dat", bus.src_data_r, 0);
        #2 rstn = 1'b1;
        tick();
        bus.src_rq_in = 1'b1; bus.src_addr_in = 3'd2;
        tick();
        bus.src_rq_in = 1'b0;
        chk("rs_fifo_clr", bus.src_busy, 1);
        push(3'd2, 16'h2222);
        tick(); tick();
        chk("rs_dat2", bus.src_data_r, 16'h2222);

        // 6: full FIFO with simultaneous push and pop
        for (int k = 0; k < 8; k++) push(3'd1, 16'h0060 + 16'(k));
        tick(); tick();
        chk("t6_af", bus.rd_buffer_full, 8'h02);
        bus.src_rq_in = 1'b1; bus.src_addr_in = 3'd1;
        bus.valid_from_bus = 1'b1; bus.addr_from_bus = 3'd1; bus.data_from_bus = 16'h0068;
        tick();
        bus.src_rq_in = 1'b0; bus.valid_from_bus = 1'b0;
        tick();
        chk("t6_vld", bus.src_valid_r, 1);
        chk("t6_dat", bus.src_data_r, 16'h0060);
        tick();
        chk("t6_af_keep", bus.rd_buffer_full, 8'h02);
        chk("t6_ovf0", bus.ovf_flag, 0);
        for (int k = 1; k <= 8; k++) rd(3'd1, 16'h0060 + 16'(k), "t6_rd");
        chk("t6_ovf1", bus.ovf_flag, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
